// File: rtl/sword_strobe_driver.sv
// sword_strobe_driver: debounced button -> single-cycle sw strobe with v-ack wait, retry and done/fail status
//   clk        in  rising-edge clock shared with the sword latch
//   reset      in  synchronous active-low reset
//   btn        in  raw asynchronous push-button level
//   v          in  acknowledge level from the sword latch
//   sw         out single-cycle strobe to the latch
//   busy       out high while debouncing, strobing or waiting for ack
//   done       out high once the latch acknowledged
//   fail       out high once all retries timed out
//   press_cnt  out saturating count of acknowledged presses (only with SWORD_DRV_PRESS_CNT_EN)
//   retry_cnt  out re-strobes used for the current press
module sword_strobe_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT = 8,
  parameter int MAX_RETRY = 3,
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn,
  input  logic          v,
  output logic          sw,
  output logic          busy,
  output logic          done,
  output logic          fail,
`ifdef SWORD_DRV_PRESS_CNT_EN
  output logic [7:0]    press_cnt,
`endif
  output logic [RW-1:0] retry_cnt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, STROBE, WAIT_ACK, DONE, FAIL} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic sw_q, busy_q, done_q, fail_q;
  logic bs;
  assign bs = sync_q[1];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    timer_d = timer_q;
    retry_d = retry_q;
    case (state_q)
      IDLE: if (bs) begin
        state_d = DEBOUNCE;
        cnt_d = CW'(1);
      end
      DEBOUNCE: if (!bs) begin
        state_d = IDLE;
        cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) state_d = STROBE;
      else cnt_d = cnt_q + CW'(1);
      STROBE: begin
        state_d = WAIT_ACK;
        timer_d = '0;
      end
      WAIT_ACK: if (v) state_d = DONE;
      else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
        state_d = (retry_q < RW'(MAX_RETRY)) ? STROBE : FAIL;
        retry_d = (retry_q < RW'(MAX_RETRY)) ? retry_q + RW'(1) : retry_q;
      end else timer_d = timer_q + TW'(1);
      DONE: if (!v && !bs) begin
        state_d = IDLE;
        retry_d = '0;
      end
      FAIL: if (!bs) begin
        state_d = IDLE;
        retry_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are flopped from the next state so they line up with state_q without extra latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sync_q <= '0;
      cnt_q <= '0;
      timer_q <= '0;
      retry_q <= '0;
      sw_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], btn};
      cnt_q <= cnt_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      sw_q <= state_d == STROBE;
      busy_q <= state_d inside {DEBOUNCE, STROBE, WAIT_ACK};
      done_q <= state_d == DONE;
      fail_q <= state_d == FAIL;
    end
  end
  assign sw = sw_q;
  assign busy = busy_q;
  assign done = done_q;
  assign fail = fail_q;
  assign retry_cnt = retry_q;
`ifdef SWORD_DRV_PRESS_CNT_EN
  logic [7:0] press_q;
  always_ff @(posedge clk) begin
    if (!reset) press_q <= '0;
    else if (state_q == WAIT_ACK && state_d == DONE && press_q != 8'hff) press_q <= press_q + 8'd1;
  end
  assign press_cnt = press_q;
`endif
endmodule
